// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state type and digit-count helpers for addsub_serial
package addsub_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic int num_digits(int width, int digit);
    return width / digit;
  endfunction
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit ripple add/sub slice (b inverted when en=1)
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             en,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);
  logic c;
  logic bb;
  // chain of 1-bit cells; subtract feeds ~b so the carry is an inverted borrow
  always_comb begin
    c = cin;
    bb = 1'b0;
    sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      bb = b[i] ^ en;
      sum[i] = a[i] ^ bb ^ c;
      c = (a[i] & bb) | (c & (a[i] ^ bb));
    end
    cout = c;
  end
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial add/subtract, one DIGIT-bit slice per clock
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);

  if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, en_q, en_d, done_q, done_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d, full;
  logic [DIGIT-1:0] da, db, ds;
  logic             dc, last;

  assign da   = a_q[cnt_q*DIGIT +: DIGIT];
  assign db   = b_q[cnt_q*DIGIT +: DIGIT];
  assign last = (cnt_q == CW'(N - 1));

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a(da), .b(db), .cin(carry_q), .en(en_q), .sum(ds), .cout(dc)
  );

  // partial result with the current digit merged in
  always_comb begin
    full = acc_q;
    full[cnt_q*DIGIT +: DIGIT] = ds;
  end

  // next state: latch operands on start, step one digit per RUN cycle, publish on the last
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    en_d    = en_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        a_d     = a;
        b_d     = b;
        en_d    = en;
        carry_d = cin ^ en;
      end
    end else begin
      acc_d   = full;
      carry_d = dc;
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      if (last) begin
        state_d = IDLE;
        done_d  = 1'b1;
        sum_d   = full;
        cout_d  = dc ^ en_q;
        ovf_d   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ en_q)) && (full[WIDTH-1] != a_q[WIDTH-1]);
        zero_d  = ~|full;
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      en_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      en_q    <= en_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed vectors, handshake corner cases and a small multi-config regression
module tb_addsub_serial;
  logic clk, rst_n, start, en, cin;
  logic [15:0] a, b, sum;
  logic [7:0] a8, b8, sum8;
  logic [11:0] a12, b12, sum12;
  logic busy, done, cout, ovf, zero;
  logic busy8, done8, cout8, ovf8, zero8;
  logic busy12, done12, cout12, ovf12, zero12;
  int checks = 0;
  int errors = 0;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );
  addsub_serial #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .a(a8), .b(b8), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );
  addsub_serial #(.WIDTH(12), .DIGIT(3)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .a(a12), .b(b12), .cin(cin),
    .busy(busy12), .done(done12), .sum(sum12), .cout(cout12), .ovf(ovf12), .zero(zero12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic e, c;
    logic [15:0] s;
    logic co, ov, z;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, got, exp);
    end
  endtask

  // called at a negedge: raise start, then count edges after the accepting edge until done
  task automatic go(input logic [15:0] av, input logic [15:0] bv, input logic e, input logic c,
                    output int lat);
    a = av; b = bv; en = e; cin = c; start = 1'b1; lat = -1;
    for (int k = 0; k < 12 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); en = 1'($urandom); cin = 1'($urandom);
        chk("busy after accept", {31'd0, busy}, 32'd1);
      end
      if (done) lat = k;
    end
  endtask

  // reference arithmetic: {zero, ovf, cout, sum}
  function automatic logic [18:0] model(int w, logic [15:0] x, logic [15:0] y, logic e, logic c);
    logic [16:0] m, f;
    logic [15:0] s;
    logic co, ov;
    m = (17'd1 << w) - 17'd1;
    if (!e) begin
      f = {1'b0, x} + {1'b0, y} + {16'd0, c};
      co = f[w];
    end else begin
      f = {1'b0, x} - {1'b0, y} - {16'd0, c};
      co = ({1'b0, x} < {1'b0, y} + {16'd0, c});
    end
    s = 16'(f & m);
    ov = e ? (x[w-1] != y[w-1] && s[w-1] != x[w-1]) : (x[w-1] == y[w-1] && s[w-1] != x[w-1]);
    return {s == 16'd0, ov, co, s};
  endfunction

  initial begin
    int lat, l16, l8, l12;
    logic [18:0] r16, r8, r12, e16, e8, e12;
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{16'h1000, 16'h0FFF, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0};
    rst_n = 1'b0; start = 1'b0; en = 1'b0; cin = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0; a12 = '0; b12 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst sum", {16'd0, sum}, 32'd0);
    chk("rst cout", {31'd0, cout}, 32'd0);
    chk("rst ovf", {31'd0, ovf}, 32'd0);
    chk("rst zero", {31'd0, zero}, 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      go(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].c, lat);
      chk($sformatf("v%0d latency", i), lat, 32'd4);
      chk($sformatf("v%0d sum", i), {16'd0, sum}, {16'd0, vecs[i].s});
      chk($sformatf("v%0d cout", i), {31'd0, cout}, {31'd0, vecs[i].co});
      chk($sformatf("v%0d ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ov});
      chk($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d busy at done", i), {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d done one cycle", i), {31'd0, done}, 32'd0);
    end
    // start while busy with other operands must be ignored; outputs hold meanwhile
    a = 16'h1111; b = 16'h2222; en = 1'b0; cin = 1'b0; start = 1'b1; lat = -1;
    for (int k = 0; k < 12 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 1) begin
        chk("hold sum while busy", {16'd0, sum}, 32'h0003);
        chk("busy mid run", {31'd0, busy}, 32'd1);
        a = 16'hFFFF; b = 16'hFFFF; en = 1'b1; cin = 1'b1; start = 1'b1;
      end
      if (k == 2) start = 1'b0;
      if (done) lat = k;
    end
    chk("ignore latency", lat, 32'd4);
    chk("ignore sum", {16'd0, sum}, 32'h3333);
    chk("ignore cout", {31'd0, cout}, 32'd0);
    // start in the done cycle: back-to-back, next done N+1 cycles after this one
    go(16'h0100, 16'h0001, 1'b1, 1'b0, lat);
    chk("b2b latency", lat, 32'd4);
    chk("b2b sum", {16'd0, sum}, 32'h00FF);
    chk("b2b ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    chk("b2b done low", {31'd0, done}, 32'd0);
    chk("b2b idle", {31'd0, busy}, 32'd0);
    // reset during the second RUN cycle
    a = 16'h1234; b = 16'h0FFF; en = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst sum", {16'd0, sum}, 32'd0);
    chk("midrst cout", {31'd0, cout}, 32'd0);
    chk("midrst zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    go(16'h4000, 16'h4000, 1'b0, 1'b0, lat);
    chk("post rst latency", lat, 32'd4);
    chk("post rst sum", {16'd0, sum}, 32'h8000);
    chk("post rst ovf", {31'd0, ovf}, 32'd1);
    chk("post rst cout", {31'd0, cout}, 32'd0);
    repeat (6) @(negedge clk);
    // regression over three geometries at once
    for (int it = 0; it < 20; it++) begin
      a = 16'($urandom); b = 16'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      a12 = 12'($urandom); b12 = 12'($urandom); en = 1'($urandom); cin = 1'($urandom);
      e16 = model(16, a, b, en, cin);
      e8 = model(8, {8'd0, a8}, {8'd0, b8}, en, cin);
      e12 = model(12, {4'd0, a12}, {4'd0, b12}, en, cin);
      start = 1'b1; l16 = -1; l8 = -1; l12 = -1;
      r16 = '0; r8 = '0; r12 = '0;
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        if (k == 0) start = 1'b0;
        if (done && l16 < 0) begin l16 = k; r16 = {zero, ovf, cout, sum}; end
        if (done8 && l8 < 0) begin l8 = k; r8 = {zero8, ovf8, cout8, 8'd0, sum8}; end
        if (done12 && l12 < 0) begin l12 = k; r12 = {zero12, ovf12, cout12, 4'd0, sum12}; end
      end
      chk($sformatf("rnd%0d w16 lat", it), l16, 32'd4);
      chk($sformatf("rnd%0d w16 res", it), {13'd0, r16}, {13'd0, e16});
      chk($sformatf("rnd%0d w8 lat", it), l8, 32'd1);
      chk($sformatf("rnd%0d w8 res", it), {13'd0, r8}, {13'd0, e8});
      chk($sformatf("rnd%0d w12 lat", it), l12, 32'd4);
      chk($sformatf("rnd%0d w12 res", it), {13'd0, r12}, {13'd0, e12});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 4, bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT, and elaboration SHALL fail otherwise.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 en  input  1  mode: 0 = add, 1 = subtract; sampled with start.
REQ-007 a, b  input  WIDTH each  operands; sampled with start.
REQ-008 cin  input  1  carry-in (add) or borrow-in (subtract); sampled with start.
REQ-009 busy  output  1  operation in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry-out (add) or borrow-out (subtract).
REQ-013 ovf  output  1  two's-complement overflow.
REQ-014 zero  output  1  high when sum is all zeros.

Function
REQ-015 N = WIDTH/DIGIT; the FSM SHALL have the states IDLE and RUN.
REQ-016 IDLE with start=1 at an edge: latch a, b, en, cin; clear digit counter; go to RUN; busy=1 from that edge.
REQ-017 RUN: process digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT) per cycle, LSB digit first, with an internal carry register propagated between digits.
REQ-018 Add: sum = a + b + cin mod 2^WIDTH; cout = bit WIDTH of the full sum.
REQ-019 Subtract: sum = a - b - cin mod 2^WIDTH, computed as a + ~b + ~cin; cout = 1 iff a < b + cin (unsigned borrow), i.e. the inverted internal carry.
REQ-020 ovf, add: a[MSB]==b[MSB] and sum[MSB]!=a[MSB]; subtract: a[MSB]!=b[MSB] and sum[MSB]!=a[MSB].
REQ-021 Latency: start accepted at edge t0 -> sum/cout/ovf/zero updated and done=1 at edge t0+N; at the same edge busy=0 and the FSM returns to IDLE.
REQ-022 done SHALL be high for exactly one cycle per accepted start.
REQ-023 sum/cout/ovf/zero SHALL change only at completion edges; they hold their values otherwise, including while busy.
REQ-024 start while busy=1 SHALL be ignored, with no effect on the operation or latched operands.
REQ-025 start high in the done cycle SHALL be accepted (FSM is IDLE), giving back-to-back operations every N+1 cycles.
REQ-026 Operand inputs SHALL be don't-care after the accepting edge.
REQ-027 DIGIT == WIDTH SHALL yield N=1 (one RUN cycle), with the same handshake.

Reset
REQ-028 rst_n low, at any time including mid-RUN: FSM=IDLE, counter=0, carry register=0, busy=0, done=0, sum=0, cout=0, ovf=0, zero=1.
REQ-029 An operation interrupted by reset SHALL produce no done pulse.
REQ-030 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-031 Package addsub_pkg SHALL hold the FSM state typedef and the N / counter-width computation.
REQ-032 One sub-module, addsub_digit: combinational DIGIT-bit slice (a, b, cin, en -> sum, cout) with per-bit carry logic equivalent to the existing 1-bit add/sub cell; instantiated once and reused each cycle.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-033 Add 0x1234 + 0x0FFF, cin=0 -> sum=0x2233, cout=0, ovf=0, zero=0; done exactly 4 cycles after the start edge.
REQ-034 Add 0x7FFF + 0x0001 -> sum=0x8000, ovf=1, cout=0; add 0xFFFF + 0x0000, cin=1 -> sum=0x0000, cout=1, zero=1.
REQ-035 Subtract 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=1, ovf=0; subtract 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1, cout=0.
REQ-036 start pulsed while busy with different operands -> ignored, first result unchanged; start in the done cycle -> second result done 5 cycles after the first done.
REQ-037 rst_n low for 1 cycle during RUN cycle 2 -> all outputs at reset values, no done; a new start afterwards completes normally.
REQ-038 Random regression for (WIDTH, DIGIT) in {(16,4), (8,8), (12,3)} against a reference model.
